// File: rtl/instr_fetch_unit_pkg.sv
// cpu_pkg: widths, opcodes, NOP word, key and
// fetch-unit state encoding shared with the 19-bit CPU core.
package cpu_pkg;

  localparam int INSTR_W = 19;

  localparam logic [4:0] OP_NOP = 5'b10001;

  localparam logic [INSTR_W-1:0] NOP_WORD =
    {OP_NOP, 14'd0};

  localparam logic [INSTR_W-1:0] ENC_KEY =
    19'h1F1F1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT
  } ifu_state_t;

  function automatic logic [INSTR_W-1:0] decrypt(
    input logic [INSTR_W-1:0] w
  );
    return w ^ ENC_KEY;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: load stream, run control, pc/instr, status.
// master = program loader + CPU side, slave = instr_fetch_unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  import cpu_pkg::*;

  logic               load_start;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               load_ready;
  logic               run_start;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W:0]    prog_len;
  logic               load_err;
  logic               halted;

  modport master (
    output load_start, load_valid, load_data,
    output load_last, run_start, pc,
    input  load_ready, instr, instr_valid,
    input  prog_len, load_err, halted
  );

  modport slave (
    input  load_start, load_valid, load_data,
    input  load_last, run_start, pc,
    output load_ready, instr, instr_valid,
    output prog_len, load_err, halted
  );

endinterface

// File: rtl/instr_fetch_unit_prog_ram.sv
// ifu_prog_ram: DEPTH x WIDTH store, one write port and one
// registered read port. Ports: clk, we/wr_addr/wr_data, rd_en/rd_addr/rd_data.
module ifu_prog_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 19
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: loads a program over a valid/ready stream and serves
// instr for pc with 1-cycle latency, NOP+HALT past the program end.
// Ports: clk, rst_n (async, active low), ifu (instr_fetch_unit_if.slave).
// Build option: define IFU_DECRYPT_EN to XOR fetched words with ENC_KEY.
module instr_fetch_unit #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [18:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic clk,
  input  logic rst_n,
  instr_fetch_unit_if.slave ifu
);
  import cpu_pkg::*;

  localparam logic [ADDR_W:0] LAST_IDX =
    (ADDR_W+1)'(DEPTH-1);

  ifu_state_t         state;
  logic [ADDR_W:0]    wr_ptr;
  logic               we;
  logic               rd_en;
  logic               in_range;
  logic [INSTR_W-1:0] ram_q;
  logic [INSTR_W-1:0] word;

  assign we = (state == S_LOAD) &&
              ifu.load_valid && ifu.load_ready;

  // Full-width compare: pc >= DEPTH can never alias a low index.
  assign in_range = ifu.pc < INSTR_W'(ifu.prog_len);
  assign rd_en = (state == S_RUN) && in_range;

  ifu_prog_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (INSTR_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (ifu.load_data),
    .rd_en   (rd_en),
    .rd_addr (ifu.pc[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

`ifdef IFU_DECRYPT_EN
  assign word = decrypt(ram_q);
`else
  assign word = ram_q;
`endif

  // Only a real fetched word is shown; the substitute NOP is never keyed.
  assign ifu.instr = ifu.instr_valid ? word : NOP_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      ifu.prog_len    <= '0;
      ifu.load_err    <= 1'b0;
      ifu.load_ready  <= 1'b0;
      ifu.halted      <= 1'b0;
      ifu.instr_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (ifu.load_start) begin
            state          <= S_LOAD;
            wr_ptr         <= '0;
            ifu.prog_len   <= '0;
            ifu.load_err   <= 1'b0;
            ifu.load_ready <= 1'b1;
            ifu.halted     <= 1'b0;
          end else if (ifu.run_start) begin
            if (ifu.prog_len != '0) begin
              state      <= S_RUN;
              ifu.halted <= 1'b0;
            end else begin
              state      <= S_HALT;
              ifu.halted <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (we) begin
            wr_ptr       <= wr_ptr + 1'b1;
            ifu.prog_len <= wr_ptr + 1'b1;
            if (ifu.load_last) begin
              state          <= S_IDLE;
              ifu.load_ready <= 1'b0;
            end else if (wr_ptr == LAST_IDX) begin
              state          <= S_IDLE;
              ifu.load_ready <= 1'b0;
              ifu.load_err   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (in_range) begin
            ifu.instr_valid <= 1'b1;
          end else begin
            ifu.instr_valid <= 1'b0;
            ifu.halted      <= 1'b1;
            state           <= S_HALT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-side counterpart of the 19-bit CPU core: the CPU consumes instructions, and this block supplies them.
- Holds a DEPTH x 19 program store, loaded word-by-word over a valid/ready stream.
- Returns the instruction addressed by the CPU's pc with 1-cycle registered latency.
- Tracks program length and substitutes NOP once pc runs past the loaded program, entering HALT.

Parameters:
- DEPTH, 256, program store depth in 19-bit words (power of two).
- ADDR_W, 8, log2(DEPTH); low bits of pc used as the store index.
- NOP_WORD, 19'h44000, opcode 5'b10001 with zero fields; the CPU treats it as a no-op (default branch).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse; begin a program load at address 0.
- load_valid  in  1  load_data is valid.
- load_data  in  19  program word.
- load_last  in  1  qualifies the final word of the load.
- load_ready  out  1  block accepts a load word this cycle.
- run_start  in  1  pulse; enter RUN.
- pc  in  19  CPU program counter.
- instr  out  19  instruction to the CPU.
- instr_valid  out  1  instr holds a fetched program word (not substitute NOP).
- prog_len  out  ADDR_W+1  number of words loaded (0..DEPTH).
- load_err  out  1  sticky; set on overflow; cleared by load_start.
- halted  out  1  state == HALT.

Behaviour:
- States: IDLE, LOAD, RUN, HALT. Reset values:
  - state = IDLE.
  - instr = NOP_WORD; instr_valid = 0.
  - prog_len = 0; load_err = 0.
  - load_ready = 0; halted = 0.
  - Store contents are not reset.
- IDLE:
  - load_start -> LOAD, wr_ptr = 0, prog_len = 0, load_err = 0.
  - run_start with prog_len != 0 -> RUN.
  - run_start with prog_len == 0 -> HALT.
  - If load_start and run_start arrive in the same cycle, load_start wins.
- LOAD:
  - load_ready = 1 while wr_ptr < DEPTH.
  - A word is accepted on load_valid & load_ready: mem[wr_ptr] = load_data, wr_ptr += 1, prog_len = wr_ptr + 1.
  - Accepted word with load_last -> IDLE the next cycle.
  - On the DEPTH-th accepted word without load_last: set load_err, deassert load_ready, go to IDLE. prog_len stays at DEPTH.
  - run_start is ignored in LOAD.
- RUN, evaluated each cycle on the registered pc:
  - If pc < prog_len (full 19-bit compare): instr = mem[pc[ADDR_W-1:0]], instr_valid = 1. Latency is 1 cycle from the pc edge.
  - Else: instr = NOP_WORD, instr_valid = 0, state -> HALT. pc values >= DEPTH always halt; they never wrap the index.
  - load_start is ignored in RUN.
- HALT:
  - instr = NOP_WORD, instr_valid = 0, halted = 1.
  - load_start -> LOAD.
  - run_start with prog_len != 0 -> RUN.
  - A backward jump (pc < prog_len) does not leave HALT by itself.
- Reset mid-LOAD or mid-RUN: immediate return to reset values. Words already written remain in the store but are unreachable, because prog_len = 0.
- load_valid without load_ready is not a transfer, and the producer holds load_data.

Optional Feature:
- IFU_DECRYPT_EN defined:
  - Store holds encrypted words.
  - In RUN, instr = mem[idx] ^ 19'h1F1F1, using the same key as the CPU's encrypt opcodes.
  - NOP_WORD is never XORed.
- IFU_DECRYPT_EN undefined: plain passthrough of stored words. Port list is unchanged.

Decomposition:
- Shared package cpu_pkg contains:
  - state encoding enum.
  - INSTR_W = 19.
  - NOP_WORD.
  - ENC_KEY = 19'h1F1F1.
  - CPU opcode constants, shared with the CPU core.
- One sub-module, ifu_prog_ram: single write port and one registered read port, DEPTH x INSTR_W.

Test Plan:
- Reset, then load 3 words 19'h00401, 19'h04802, 19'h44000 with load_last on the third.
  - prog_len = 3, state IDLE.
  - run_start with pc = 0,1,2 gives instr 19'h00401, 19'h04802, 19'h44000 one cycle later, each with instr_valid = 1.
- Same program with pc = 3: instr = 19'h44000, instr_valid = 0, halted = 1 next cycle. A following pc = 0 keeps halted = 1.
- Load 256 words with no load_last: load_ready drops after the 256th word, load_err = 1, prog_len = 256. A 257th load_valid is not accepted.
- Hold load_valid low for 5 cycles mid-load: no write occurs and wr_ptr is unchanged. Resume and finish: contents match in order.
- Assert rst_n = 0 mid-RUN at pc = 1: instr = 19'h44000, instr_valid = 0, prog_len = 0 asynchronously. A later run_start goes to HALT.
- IFU_DECRYPT_EN: load 19'h1F1F1 ^ 19'h00401 = 19'h1F5F0; fetch at pc = 0 returns 19'h00401.
